// File: rtl/ppu_oam_eval.sv
// ppu_oam_eval: primary sprite attribute memory with CPU register access,
// plus the per-scanline sprite evaluator that fills the 32-byte secondary
// OAM with up to eight in-range sprites and flags sprite overflow.
module ppu_oam_eval (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [2:0] ri_sel_in,
    input  logic [7:0] ri_d_in,
    input  logic       ri_wr_in,
    input  logic       ri_rd_in,
    output logic [7:0] ri_d_out,
    input  logic       eval_start_in,
    input  logic [7:0] scanline_in,
    input  logic       spr_h16_in,
    input  logic [4:0] sec_idx_in,
    output logic [7:0] sec_d_out,
    output logic [3:0] sec_cnt_out,
    output logic       overflow_out,
    output logic       busy_out,
    output logic       done_out
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COPY,
        DONE
    } state_t;

    state_t     state;

    logic [7:0] oam [0:255];
    logic [7:0] sec [0:31];
    logic [7:0] oam_addr;

    logic [7:0] scanline_q;
    logic       h16_q;
    logic [5:0] n;
    logic [1:0] k;
    logic [3:0] cnt;
    logic       overflow;
    logic       busy;
    logic       done;

    logic       addr_wr;
    logic       data_wr;
    logic [7:0] y_byte;
    logic [8:0] diff;
    logic       in_range;
    logic [7:0] copy_byte;
    logic [7:0] oam_rd_byte;

    // Register reads have no side effects here; the strobe is kept only
    // for interface completeness.
    logic       rd_strobe_unused;
    assign rd_strobe_unused = ri_rd_in;

    assign addr_wr = ri_wr_in && (ri_sel_in == 3'd3);
    assign data_wr = ri_wr_in && (ri_sel_in == 3'd4);

    // OAMADDR: loaded directly, or post-incremented (8-bit wrap) by OAMDATA writes
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            oam_addr <= 8'h00;
        end else if (addr_wr) begin
            oam_addr <= ri_d_in;
        end else if (data_wr) begin
            oam_addr <= oam_addr + 8'd1;
        end
    end

    // Primary OAM storage; contents deliberately survive reset
    always_ff @(posedge clk_in) begin
        if (data_wr) begin
            oam[oam_addr] <= ri_d_in;
        end
    end

    // Attribute bytes have three unimplemented bits that always read as zero
    assign oam_rd_byte = oam[oam_addr];
    assign ri_d_out    = (oam_addr[1:0] == 2'd2) ? (oam_rd_byte & 8'hE3) : oam_rd_byte;

    // Range test for sprite n; the ninth diff bit catches sprites below the line
    assign y_byte    = oam[{n, 2'b00}];
    assign diff      = {1'b0, scanline_q} - {1'b0, y_byte};
    assign in_range  = !diff[8] && (diff[7:0] < (h16_q ? 8'd16 : 8'd8));
    assign copy_byte = oam[{n, k}];

    // Evaluation FSM: a start pulse in any state clears and restarts the scan
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            scanline_q <= 8'h00;
            h16_q      <= 1'b0;
            n          <= 6'd0;
            k          <= 2'd0;
            cnt        <= 4'd0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                sec[i] <= 8'hFF;
            end
        end else begin
            done <= 1'b0;
            if (eval_start_in) begin
                for (int i = 0; i < 32; i++) begin
                    sec[i] <= 8'hFF;
                end
                scanline_q <= scanline_in;
                h16_q      <= spr_h16_in;
                cnt        <= 4'd0;
                overflow   <= 1'b0;
                n          <= 6'd0;
                k          <= 2'd0;
                busy       <= 1'b1;
                state      <= SCAN;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    SCAN: begin
                        if (in_range && (cnt == 4'd8)) begin
                            overflow <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else if (in_range) begin
                            k     <= 2'd0;
                            state <= COPY;
                        end else if (n == 6'd63) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            n <= n + 6'd1;
                        end
                    end
                    COPY: begin
                        sec[{cnt[2:0], k}] <= copy_byte;
                        k <= k + 2'd1;
                        if (k == 2'd3) begin
                            cnt <= cnt + 4'd1;
                            if (n == 6'd63) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                n     <= n + 6'd1;
                                state <= SCAN;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sec_d_out    = sec[sec_idx_in];
    assign sec_cnt_out  = cnt;
    assign overflow_out = overflow;
    assign busy_out     = busy;
    assign done_out     = done;

endmodule

// File: tb/tb_ppu_oam_eval.sv
// tb_ppu_oam_eval: directed checks of the OAM register port, attribute read
// masking, sprite evaluation timing, height boundaries, overflow, restart
// and asynchronous reset during a copy.
module tb_ppu_oam_eval;

    logic       clk_in;
    logic       rst_in;
    logic [2:0] ri_sel_in;
    logic [7:0] ri_d_in;
    logic       ri_wr_in;
    logic       ri_rd_in;
    logic [7:0] ri_d_out;
    logic       eval_start_in;
    logic [7:0] scanline_in;
    logic       spr_h16_in;
    logic [4:0] sec_idx_in;
    logic [7:0] sec_d_out;
    logic [3:0] sec_cnt_out;
    logic       overflow_out;
    logic       busy_out;
    logic       done_out;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_sec [0:31];

    ppu_oam_eval dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .ri_sel_in     (ri_sel_in),
        .ri_d_in       (ri_d_in),
        .ri_wr_in      (ri_wr_in),
        .ri_rd_in      (ri_rd_in),
        .ri_d_out      (ri_d_out),
        .eval_start_in (eval_start_in),
        .scanline_in   (scanline_in),
        .spr_h16_in    (spr_h16_in),
        .sec_idx_in    (sec_idx_in),
        .sec_d_out     (sec_d_out),
        .sec_cnt_out   (sec_cnt_out),
        .overflow_out  (overflow_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    // 100 MHz clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Hard stop in case anything stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One register write strobe, driven between falling edges
    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] d);
        @(negedge clk_in);
        ri_sel_in = sel;
        ri_d_in   = d;
        ri_wr_in  = 1'b1;
        @(negedge clk_in);
        ri_wr_in  = 1'b0;
    endtask

    // Fill primary OAM: every Y byte = y, all other bytes 0
    task automatic fillOam(input logic [7:0] y);
        applyStimulus(3'd3, 8'h00);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(3'd4, (i % 4 == 0) ? y : 8'h00);
        end
    endtask

    // Returns on the falling edge inside cycle 1 after the start edge
    task automatic startEval(input logic [7:0] sl, input logic h16);
        @(negedge clk_in);
        eval_start_in = 1'b1;
        scanline_in   = sl;
        spr_h16_in    = h16;
        @(negedge clk_in);
        eval_start_in = 1'b0;
    endtask

    // Cycle number (counted from the start edge) at which done_out is seen; 0 on timeout
    task automatic waitDone(input int already, output int cyc);
        cyc = already;
        while (!done_out && cyc < 300) begin
            @(negedge clk_in);
            cyc++;
        end
        if (!done_out) cyc = 0;
    endtask

    task automatic checkSec(input string tag);
        for (int i = 0; i < 32; i++) begin
            sec_idx_in = i[4:0];
            #1;
            checkOutput($sformatf("%s_sec%0d", tag, i), {24'd0, sec_d_out}, {24'd0, exp_sec[i]});
        end
    endtask

    initial begin
        int cyc;
        int done_seen;

        rst_in        = 1'b1;
        ri_sel_in     = 3'd0;
        ri_d_in       = 8'h00;
        ri_wr_in      = 1'b0;
        ri_rd_in      = 1'b0;
        eval_start_in = 1'b0;
        scanline_in   = 8'h00;
        spr_h16_in    = 1'b0;
        sec_idx_in    = 5'd0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        $display("[TB] reset state");
        checkOutput("rst_cnt",  {28'd0, sec_cnt_out}, 32'd0);
        checkOutput("rst_ovf",  {31'd0, overflow_out}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_out}, 32'd0);
        checkOutput("rst_done", {31'd0, done_out}, 32'd0);
        checkOutput("rst_sec0", {24'd0, sec_d_out}, 32'hFF);

        $display("[TB] register writes with auto-increment and wrap");
        applyStimulus(3'd3, 8'hFE);
        applyStimulus(3'd4, 8'h11);
        applyStimulus(3'd4, 8'h22);
        applyStimulus(3'd4, 8'h33);
        applyStimulus(3'd4, 8'h44);
        applyStimulus(3'd3, 8'h00);
        checkOutput("oam00", {24'd0, ri_d_out}, 32'h33);
        applyStimulus(3'd5, 8'h77);
        applyStimulus(3'd2, 8'h77);
        checkOutput("ignored_sel", {24'd0, ri_d_out}, 32'h33);
        @(negedge clk_in);
        ri_rd_in = 1'b1;
        @(negedge clk_in);
        ri_rd_in = 1'b0;
        @(negedge clk_in);
        checkOutput("read_no_inc", {24'd0, ri_d_out}, 32'h33);
        applyStimulus(3'd3, 8'h01);
        checkOutput("oam01", {24'd0, ri_d_out}, 32'h44);
        applyStimulus(3'd3, 8'hFE);
        checkOutput("oamFE_masked", {24'd0, ri_d_out}, 32'h01);
        applyStimulus(3'd3, 8'hFF);
        checkOutput("oamFF", {24'd0, ri_d_out}, 32'h22);

        $display("[TB] attribute read masking");
        applyStimulus(3'd3, 8'h02);
        applyStimulus(3'd4, 8'hFF);
        applyStimulus(3'd3, 8'h02);
        checkOutput("attr_mask", {24'd0, ri_d_out}, 32'hE3);

        $display("[TB] single sprite in range");
        fillOam(8'hF0);
        applyStimulus(3'd3, 8'd20);
        applyStimulus(3'd4, 8'h10);
        applyStimulus(3'd4, 8'h42);
        applyStimulus(3'd4, 8'h01);
        applyStimulus(3'd4, 8'h80);
        startEval(8'h15, 1'b0);
        checkOutput("single_busy", {31'd0, busy_out}, 32'd1);
        waitDone(1, cyc);
        checkOutput("single_lat", cyc, 32'd69);
        checkOutput("single_cnt", {28'd0, sec_cnt_out}, 32'd1);
        checkOutput("single_ovf", {31'd0, overflow_out}, 32'd0);
        @(negedge clk_in);
        checkOutput("single_done_pulse", {31'd0, done_out}, 32'd0);
        checkOutput("single_idle_busy", {31'd0, busy_out}, 32'd0);
        for (int i = 0; i < 32; i++) exp_sec[i] = 8'hFF;
        exp_sec[0] = 8'h10;
        exp_sec[1] = 8'h42;
        exp_sec[2] = 8'h01;
        exp_sec[3] = 8'h80;
        checkSec("single");

        $display("[TB] sprite height boundaries");
        fillOam(8'hF0);
        applyStimulus(3'd3, 8'h00);
        applyStimulus(3'd4, 8'h20);
        startEval(8'h2F, 1'b1);
        waitDone(1, cyc);
        checkOutput("h16_2F_lat", cyc, 32'd69);
        checkOutput("h16_2F_cnt", {28'd0, sec_cnt_out}, 32'd1);
        startEval(8'h30, 1'b1);
        waitDone(1, cyc);
        checkOutput("h16_30_lat", cyc, 32'd65);
        checkOutput("h16_30_cnt", {28'd0, sec_cnt_out}, 32'd0);
        startEval(8'h1F, 1'b1);
        waitDone(1, cyc);
        checkOutput("h16_1F_cnt", {28'd0, sec_cnt_out}, 32'd0);
        startEval(8'h27, 1'b0);
        waitDone(1, cyc);
        checkOutput("h8_27_cnt", {28'd0, sec_cnt_out}, 32'd1);
        startEval(8'h28, 1'b0);
        waitDone(1, cyc);
        checkOutput("h8_28_cnt", {28'd0, sec_cnt_out}, 32'd0);

        $display("[TB] CPU write during evaluation");
        startEval(8'h50, 1'b0);
        repeat (18) @(negedge clk_in);
        applyStimulus(3'd3, 8'hA0);
        applyStimulus(3'd4, 8'h50);
        waitDone(23, cyc);
        checkOutput("midwr_lat", cyc, 32'd69);
        checkOutput("midwr_cnt", {28'd0, sec_cnt_out}, 32'd1);
        sec_idx_in = 5'd0;
        #1;
        checkOutput("midwr_sec0", {24'd0, sec_d_out}, 32'h50);

        $display("[TB] overflow");
        fillOam(8'hF0);
        applyStimulus(3'd3, 8'h00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(3'd4, 8'h00);
            applyStimulus(3'd4, 8'(i + 1));
            applyStimulus(3'd4, 8'h1C);
            applyStimulus(3'd4, 8'(8'h10 + i));
        end
        startEval(8'h03, 1'b0);
        waitDone(1, cyc);
        checkOutput("ovf_lat", cyc, 32'd42);
        checkOutput("ovf_cnt", {28'd0, sec_cnt_out}, 32'd8);
        checkOutput("ovf_flag", {31'd0, overflow_out}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_sec[4*i]     = 8'h00;
            exp_sec[4*i + 1] = 8'(i + 1);
            exp_sec[4*i + 2] = 8'h1C;
            exp_sec[4*i + 3] = 8'(8'h10 + i);
        end
        checkSec("ovf");

        $display("[TB] restart mid-evaluation");
        done_seen = 0;
        startEval(8'h03, 1'b0);
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk_in);
            cyc++;
            if (done_out) done_seen++;
        end
        checkOutput("restart_pre_cnt", {28'd0, sec_cnt_out}, 32'd1);
        checkOutput("restart_pre_busy", {31'd0, busy_out}, 32'd1);
        eval_start_in = 1'b1;
        scanline_in   = 8'h80;
        spr_h16_in    = 1'b0;
        @(negedge clk_in);
        eval_start_in = 1'b0;
        waitDone(1, cyc);
        checkOutput("restart_lat", cyc, 32'd65);
        if (done_out) done_seen++;
        repeat (20) begin
            @(negedge clk_in);
            if (done_out) done_seen++;
        end
        checkOutput("restart_done_count", done_seen, 32'd1);
        checkOutput("restart_cnt", {28'd0, sec_cnt_out}, 32'd0);
        checkOutput("restart_ovf", {31'd0, overflow_out}, 32'd0);
        for (int i = 0; i < 32; i++) exp_sec[i] = 8'hFF;
        checkSec("restart");

        $display("[TB] reset during copy");
        checkOutput("pre_rst_addr_rd", {24'd0, ri_d_out}, 32'hF0);
        startEval(8'h03, 1'b0);
        repeat (2) @(negedge clk_in);
        sec_idx_in = 5'd0;
        #1;
        checkOutput("copy_busy", {31'd0, busy_out}, 32'd1);
        checkOutput("copy_sec0", {24'd0, sec_d_out}, 32'h00);
        rst_in = 1'b1;
        #1;
        checkOutput("arst_busy", {31'd0, busy_out}, 32'd0);
        checkOutput("arst_cnt",  {28'd0, sec_cnt_out}, 32'd0);
        checkOutput("arst_sec0", {24'd0, sec_d_out}, 32'hFF);
        checkOutput("arst_ovf",  {31'd0, overflow_out}, 32'd0);
        checkOutput("arst_addr_rd", {24'd0, ri_d_out}, 32'h00);
        @(negedge clk_in);
        rst_in = 1'b0;
        done_seen = 0;
        repeat (100) begin
            @(negedge clk_in);
            if (done_out) done_seen++;
        end
        checkOutput("arst_no_done", done_seen, 32'd0);
        checkOutput("arst_idle_busy", {31'd0, busy_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
